// File: rtl/i2c_req_arbiter_pkg.sv
// Shared FSM state, response codes and FMC424 I2C target addresses for the
// request arbiter in front of the I2C byte master.
package fmc_i2c_pkg;

  localparam int MAX_REQ = 4;
  localparam int OWNER_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } arb_state_t;

  typedef enum logic [1:0] {
    I2C_OK      = 2'b00,
    I2C_NACK    = 2'b01,
    I2C_TIMEOUT = 2'b10
  } i2c_err_t;

  localparam logic [6:0] ADDR_CPLD    = 7'b0111110;
  localparam logic [6:0] ADDR_SI5338B = 7'b1110000;
  localparam logic [6:0] ADDR_QSFP    = 7'b1010000;

  // Index of the set bit of a one-hot (or all-zero) vector
  function automatic logic [OWNER_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [OWNER_W-1:0] idx;
    idx = {OWNER_W{1'b0}};
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = OWNER_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester and byte-master signals of the arbiter; slave is the arbiter's
// view, master is the environment (requesters plus byte master).
interface i2c_req_arbiter_if #(
  parameter int NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_rw;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_rdata;
  logic [1:0]           rsp_err;
  logic                 m_start;
  logic                 m_rw;
  logic [6:0]           m_addr;
  logic [7:0]           m_wdata;
  logic                 m_done;
  logic                 m_nack;
  logic [7:0]           m_rdata;
  logic                 m_abort;
  logic                 busy;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    input  m_done, m_nack, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_start, m_rw, m_addr, m_wdata, m_abort, busy
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    output m_done, m_nack, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_start, m_rw, m_addr, m_wdata, m_abort, busy
  );

endinterface

// File: rtl/i2c_req_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester
// found when searching from (last_owner+1) mod NUM_REQ.
module i2c_rr_picker
  import fmc_i2c_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [OWNER_W-1:0] i_last_owner,
  output logic [NUM_REQ-1:0] o_grant
);

  logic w_found;

  // Walk the ring starting just after the last owner; first pending request wins
  always_comb begin
    o_grant = {NUM_REQ{1'b0}};
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && i_req[i] && (((int'(i_last_owner) + k) % NUM_REQ) == i)) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end else begin
          w_found = w_found;
        end
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Arbitrates NUM_REQ requesters onto one FMC424 I2C byte master with a
// per-transaction timeout; Moore FSM, every output registered.
module i2c_req_arbiter
  import fmc_i2c_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic              CLK,
  input logic              RST,
  i2c_req_arbiter_if.slave bus
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [OWNER_W-1:0] OWNER_RST  = OWNER_W'(NUM_REQ - 1);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_owner_oh;
  logic [OWNER_W-1:0] r_owner;
  logic [OWNER_W-1:0] r_last_owner;
  logic [TIMER_W-1:0] r_timer;

  logic [NUM_REQ-1:0] w_grant;
  logic [MAX_REQ-1:0] w_grant_pad;
  logic               w_sel_rw;
  logic [6:0]         w_sel_addr;
  logic [7:0]         w_sel_wdata;

  i2c_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req        (bus.req_valid),
    .i_last_owner (r_last_owner),
    .o_grant      (w_grant)
  );

  // Steer the winner's payload onto one bus; the grant is one-hot or zero
  always_comb begin
    w_grant_pad                = {MAX_REQ{1'b0}};
    w_grant_pad[NUM_REQ-1:0]   = w_grant;
    w_sel_rw                   = 1'b0;
    w_sel_addr                 = 7'h00;
    w_sel_wdata                = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_rw    = w_sel_rw | (bus.req_rw[i] & w_grant[i]);
      w_sel_addr  = w_sel_addr | (bus.req_addr[7*i +: 7] & {7{w_grant[i]}});
      w_sel_wdata = w_sel_wdata | (bus.req_wdata[8*i +: 8] & {8{w_grant[i]}});
    end
  end

  // Arbiter FSM with registered handshake, command and response outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_owner_oh    <= {NUM_REQ{1'b0}};
      r_owner       <= {OWNER_W{1'b0}};
      r_last_owner  <= OWNER_RST;
      r_timer       <= {TIMER_W{1'b0}};
      bus.req_ready <= {NUM_REQ{1'b0}};
      bus.rsp_valid <= {NUM_REQ{1'b0}};
      bus.rsp_rdata <= 8'h00;
      bus.rsp_err   <= I2C_OK;
      bus.m_start   <= 1'b0;
      bus.m_rw      <= 1'b0;
      bus.m_addr    <= 7'h00;
      bus.m_wdata   <= 8'h00;
      bus.m_abort   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.req_ready <= {NUM_REQ{1'b0}};
      bus.m_start   <= 1'b0;
      bus.m_abort   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            r_state       <= ST_GRANT;
            r_owner_oh    <= w_grant;
            r_owner       <= onehot_to_idx(w_grant_pad);
            bus.req_ready <= w_grant;
            bus.m_start   <= 1'b1;
            bus.m_rw      <= w_sel_rw;
            bus.m_addr    <= w_sel_addr;
            bus.m_wdata   <= w_sel_wdata;
            bus.busy      <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          r_state <= ST_WAIT;
          r_timer <= {TIMER_W{1'b0}};
        end
        ST_WAIT: begin
          // A completion on the expiry cycle beats the timeout
          if (bus.m_done) begin
            r_state       <= ST_RESP;
            bus.rsp_valid <= r_owner_oh;
            bus.rsp_rdata <= bus.m_rw ? bus.m_rdata : 8'h00;
            bus.rsp_err   <= bus.m_nack ? I2C_NACK : I2C_OK;
          end else if (r_timer == TIMER_LAST) begin
            r_state       <= ST_RESP;
            bus.m_abort   <= 1'b1;
            bus.rsp_valid <= r_owner_oh;
            bus.rsp_rdata <= 8'h00;
            bus.rsp_err   <= I2C_TIMEOUT;
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        ST_RESP: begin
          r_state       <= ST_IDLE;
          r_last_owner  <= r_owner;
          r_timer       <= {TIMER_W{1'b0}};
          bus.rsp_valid <= {NUM_REQ{1'b0}};
          bus.rsp_rdata <= 8'h00;
          bus.rsp_err   <= I2C_OK;
          bus.m_rw      <= 1'b0;
          bus.m_addr    <= 7'h00;
          bus.m_wdata   <= 8'h00;
          bus.busy      <= 1'b0;
        end
        default: begin
          r_state       <= ST_IDLE;
          bus.rsp_valid <= {NUM_REQ{1'b0}};
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: a scoreboard queue holds the expected
// response of every issued request and is drained as rsp_valid pulses appear.
module tb_i2c_req_arbiter;
  import fmc_i2c_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [1:0] oh;
    logic [7:0] rdata;
    logic [1:0] err;
    logic       abort;
  } exp_t;

  exp_t exp_q[$];

  i2c_req_arbiter_if #(.NUM_REQ(2)) b ();

  i2c_req_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] all_outs();
    logic [63:0] v;
    v = {b.busy, b.m_start, b.m_abort, b.req_ready, b.rsp_valid, b.rsp_rdata,
         b.rsp_err, b.m_rw, b.m_addr, b.m_wdata};
    return v;
  endfunction

  // Called at the first WAIT-cycle negedge; done_after < 0 means m_done never comes
  task automatic finish_wait(input int done_after, input logic nack, input logic [7:0] rd,
                             input string tag);
    int   k;
    bit   seen;
    int   lat;
    exp_t e;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      if (k == done_after) begin
        b.m_done  = 1'b1;
        b.m_nack  = nack;
        b.m_rdata = rd;
      end
      @(negedge clk);
      b.m_done  = 1'b0;
      b.m_nack  = 1'b0;
      b.m_rdata = 8'h00;
      if (b.rsp_valid != 2'b00) seen = 1'b1;
      else k++;
    end
    check({tag, "_rsp_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      lat = (done_after >= 0) ? done_after : TMO - 1;
      check({tag, "_latency"}, 64'(k), 64'(lat));
      if (exp_q.size() == 0) begin
        check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_rsp_valid"}, 64'(b.rsp_valid), 64'(e.oh));
        check({tag, "_rsp_rdata"}, 64'(b.rsp_rdata), 64'(e.rdata));
        check({tag, "_rsp_err"}, 64'(b.rsp_err), 64'(e.err));
        check({tag, "_m_abort"}, 64'(b.m_abort), 64'(e.abort));
      end
      @(negedge clk);
      check({tag, "_idle_after"},
            64'({b.rsp_valid, b.m_abort, b.busy, b.m_addr, b.rsp_err}), 64'd0);
    end
  endtask

  // Issue one request from requester 'who' and run it to its response
  task automatic do_txn(input int who, input logic rw, input logic [6:0] addr,
                        input logic [7:0] wd, input int done_after, input logic nack,
                        input logic [7:0] rd, input string tag);
    exp_t e;
    e.oh    = (who == 0) ? 2'b01 : 2'b10;
    e.rdata = rw ? rd : 8'h00;
    e.err   = (done_after < 0) ? I2C_TIMEOUT : (nack ? I2C_NACK : I2C_OK);
    e.abort = (done_after < 0);
    exp_q.push_back(e);
    b.req_valid                = 2'b00;
    b.req_valid[who]           = 1'b1;
    b.req_rw[who]              = rw;
    b.req_addr[7*who +: 7]     = addr;
    b.req_wdata[8*who +: 8]    = wd;
    @(negedge clk);
    check({tag, "_m_start"}, 64'(b.m_start), 64'd1);
    check({tag, "_req_ready"}, 64'(b.req_ready), 64'(e.oh));
    check({tag, "_m_payload"}, 64'({b.m_rw, b.m_addr, b.m_wdata}), 64'({rw, addr, wd}));
    b.req_valid = 2'b00;
    b.req_rw    = ~b.req_rw;
    b.req_addr  = ~b.req_addr;
    b.req_wdata = ~b.req_wdata;
    @(negedge clk);
    check({tag, "_start_once"}, 64'({b.m_start, b.req_ready}), 64'd0);
    check({tag, "_payload_held"}, 64'({b.m_rw, b.m_addr, b.m_wdata}), 64'({rw, addr, wd}));
    finish_wait(done_after, nack, rd, tag);
  endtask

  initial begin
    exp_t e;
    int   w;
    logic [1:0] want_oh;
    logic       spurious;
    b.req_valid = 2'b00;
    b.req_rw    = 2'b00;
    b.req_addr  = 14'h0000;
    b.req_wdata = 16'h0000;
    b.m_done    = 1'b0;
    b.m_nack    = 1'b0;
    b.m_rdata   = 8'h00;

    #1 rst = 1'b1;
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // m_done while idle must be ignored
    b.m_done = 1'b1;
    b.m_nack = 1'b1;
    @(negedge clk);
    b.m_done = 1'b0;
    b.m_nack = 1'b0;
    check("idle_mdone_ignored", 64'({b.rsp_valid, b.busy, b.m_abort}), 64'd0);

    do_txn(0, 1'b0, ADDR_CPLD,    8'hA5, 0,       1'b0, 8'h00, "wr0");
    do_txn(1, 1'b1, ADDR_SI5338B, 8'h00, 0,       1'b0, 8'h5C, "rd1");
    do_txn(0, 1'b0, ADDR_QSFP,    8'h3C, 2,       1'b1, 8'hFF, "nack0");
    do_txn(1, 1'b0, ADDR_CPLD,    8'h81, -1,      1'b0, 8'h00, "tmo1");
    do_txn(0, 1'b1, ADDR_QSFP,    8'h00, TMO - 1, 1'b0, 8'h96, "tmo_edge0");

    // Contention: both held; last owner was 0, so grants go 1,0,1,0
    b.req_valid = 2'b11;
    b.req_rw    = 2'b00;
    b.req_addr  = {ADDR_QSFP, ADDR_CPLD};
    b.req_wdata = {8'h22, 8'h11};
    for (int t = 0; t < 4; t++) begin
      e.oh    = (t % 2 == 0) ? 2'b10 : 2'b01;
      e.rdata = 8'h00;
      e.err   = I2C_OK;
      e.abort = 1'b0;
      exp_q.push_back(e);
    end
    for (int t = 0; t < 4; t++) begin
      want_oh = (t % 2 == 0) ? 2'b10 : 2'b01;
      w = 0;
      while (b.m_start !== 1'b1 && w < 10) begin
        @(negedge clk);
        w++;
      end
      check("cont_start_seen", 64'(b.m_start), 64'd1);
      check("cont_grant", 64'(b.req_ready), 64'(want_oh));
      check("cont_addr", 64'(b.m_addr), 64'((want_oh == 2'b01) ? ADDR_CPLD : ADDR_QSFP));
      @(negedge clk);
      finish_wait(0, 1'b0, 8'h00, "cont");
      if (t == 3) b.req_valid = 2'b00;
    end
    @(negedge clk);
    check("cont_no_extra", 64'({b.m_start, b.busy}), 64'd0);

    // Reset asserted mid-WAIT: outputs clear at once, no response follows
    b.req_valid       = 2'b01;
    b.req_addr[6:0]   = ADDR_SI5338B;
    b.req_wdata[7:0]  = 8'h5A;
    @(negedge clk);
    check("rstw_grant", 64'(b.req_ready), 64'd1);
    b.req_valid = 2'b00;
    @(negedge clk);
    check("rstw_in_wait", 64'(b.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rstw_async_clear", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      spurious = spurious | (|b.rsp_valid) | b.m_abort | b.busy;
    end
    check("rstw_no_rsp", 64'(spurious), 64'd0);

    e.oh    = 2'b01;
    e.rdata = 8'h00;
    e.err   = I2C_OK;
    e.abort = 1'b0;
    exp_q.push_back(e);
    b.req_valid = 2'b11;
    b.req_rw    = 2'b00;
    b.req_addr  = {ADDR_CPLD, ADDR_QSFP};
    b.req_wdata = {8'h77, 8'h44};
    @(negedge clk);
    check("rstw_req0_first", 64'(b.req_ready), 64'd1);
    check("rstw_req0_addr", 64'(b.m_addr), 64'(ADDR_QSFP));
    b.req_valid = 2'b00;
    @(negedge clk);
    finish_wait(0, 1'b0, 8'h00, "post_rst");

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
